// File: rtl/bubble_sort_pkg.sv
// rtl/bubble_sort_pkg.sv - shared types and helpers for the multi-cycle odd-even sorter
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Parity of the first element of each compared pair; equals bit 0 of the stage index.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int stage_cnt_w(input int dim, input int ppc);
    return $clog2(dim + ppc) + 1;
  endfunction

endpackage

// File: rtl/bubble_sort_seq_oe_stage.sv
// rtl/bubble_sort_seq_oe_stage.sv - one combinational odd-even transposition stage
module oe_stage
  import bubble_sort_pkg::*;
#(
  parameter int DIM     = 10,
  parameter int WIDTH   = 8,
  parameter int DESCEND = 0,
  parameter int SIGNED  = 0
) (
  input  logic                   parity,
  input  logic [DIM*WIDTH-1:0]   in_data,
  output logic [DIM*WIDTH-1:0]   out_data,
  output logic                   any_swap
);

  logic [WIDTH-1:0] a, b;
  logic             gt, lt, sw;

  // Pairs of one parity are disjoint, so reading in_data and writing out_data never collide.
  always_comb begin
    out_data = in_data;
    any_swap = 1'b0;
    a        = '0;
    b        = '0;
    gt       = 1'b0;
    lt       = 1'b0;
    sw       = 1'b0;
    for (int k = 0; k < DIM - 1; k++) begin
      if (((k % 2) == 1) == (parity == PAR_ODD)) begin
        a  = in_data[k*WIDTH +: WIDTH];
        b  = in_data[(k+1)*WIDTH +: WIDTH];
        gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
        lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
        sw = (DESCEND != 0) ? lt : gt;
        if (sw) begin
          out_data[k*WIDTH +: WIDTH]     = b;
          out_data[(k+1)*WIDTH +: WIDTH] = a;
          any_swap                       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bubble_sort_seq.sv
// rtl/bubble_sort_seq.sv - multi-cycle odd-even transposition sorter with valid/ready handshakes
module bubble_sort_seq
  import bubble_sort_pkg::*;
#(
  parameter int DIM        = 10,
  parameter int WIDTH      = 8,
  parameter int PPC        = 1,
  parameter int DESCEND    = 0,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIM*WIDTH-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIM*WIDTH-1:0]          out_data,
  output logic                          busy,
  output logic [$clog2(DIM+PPC):0]      out_stages
);

  localparam int SW = stage_cnt_w(DIM, PPC);

  if (DIM < 2 || PPC < 1 || PPC > DIM) begin : g_param_check
    $error("bubble_sort_seq: requires DIM >= 2 and 1 <= PPC <= DIM");
  end

  state_t               state, state_n;
  logic [DIM*WIDTH-1:0] work, work_n;
  logic [SW-1:0]        g, g_n, g_plus, stg_q, stg_n;
  logic                 prev_swap, prev_swap_n;

  logic [DIM*WIDTH-1:0] chain [PPC+1];
  logic [PPC:0]         hist;
  logic [PPC-1:0]       zero_pair;
  logic                 early;

  assign chain[0] = work;
  assign hist[0]  = prev_swap;

  // Stages past DIM are bypassed; hist carries the last applied stage's swap bit down the chain.
  for (genvar gi = 0; gi < PPC; gi++) begin : g_stage
    logic [SW-1:0]        sidx;
    logic                 applied;
    logic [DIM*WIDTH-1:0] st_out;
    logic                 st_swap;

    assign sidx    = g + SW'(gi);
    assign applied = (sidx < SW'(DIM));

    oe_stage #(
      .DIM     (DIM),
      .WIDTH   (WIDTH),
      .DESCEND (DESCEND),
      .SIGNED  (SIGNED)
    ) u_stage (
      .parity   (sidx[0]),
      .in_data  (chain[gi]),
      .out_data (st_out),
      .any_swap (st_swap)
    );

    assign chain[gi+1]   = applied ? st_out : chain[gi];
    assign hist[gi+1]    = applied ? st_swap : hist[gi];
    assign zero_pair[gi] = applied & ~st_swap & ~hist[gi];
  end

  assign g_plus = g + SW'(PPC);
  assign early  = (EARLY_EXIT != 0) && (|zero_pair);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work      <= '0;
      g         <= '0;
      prev_swap <= 1'b1;
      stg_q     <= '0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      g         <= g_n;
      prev_swap <= prev_swap_n;
      stg_q     <= stg_n;
    end
  end

  always_comb begin
    state_n     = state;
    work_n      = work;
    g_n         = g;
    prev_swap_n = prev_swap;
    stg_n       = stg_q;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          work_n      = in_data;
          g_n         = '0;
          prev_swap_n = 1'b1;
          state_n     = S_SORT;
        end
      end
      S_SORT: begin
        work_n      = chain[PPC];
        g_n         = g_plus;
        prev_swap_n = hist[PPC];
        if (g_plus >= SW'(DIM) || early) begin
          state_n = S_DONE;
          stg_n   = (g_plus >= SW'(DIM)) ? SW'(DIM) : g_plus;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state == S_SORT);
  assign out_valid  = (state == S_DONE);
  assign out_data   = work;
  assign out_stages = stg_q;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// tb/tb_bubble_sort_seq.sv - directed self-checking bench for bubble_sort_seq
module tb_bubble_sort_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: ascending EE=1, 1: ascending EE=0, 2: signed descending; all DIM=4 PPC=1.
  logic        iv   [3];
  logic        ir   [3];
  logic [31:0] id   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [31:0] od   [3];
  logic        bz   [3];
  logic [3:0]  st   [3];

  logic        iv_d, ir_d, ov_d, ordy_d, bz_d;
  logic [79:0] id_d, od_d;
  logic [4:0]  st_d;

  int n_checks = 0;
  int n_err    = 0;

  bubble_sort_seq #(.DIM(4), .WIDTH(8), .PPC(1), .DESCEND(0), .SIGNED(0), .EARLY_EXIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]), .out_stages(st[0]));

  bubble_sort_seq #(.DIM(4), .WIDTH(8), .PPC(1), .DESCEND(0), .SIGNED(0), .EARLY_EXIT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]), .out_stages(st[1]));

  bubble_sort_seq #(.DIM(4), .WIDTH(8), .PPC(1), .DESCEND(1), .SIGNED(1), .EARLY_EXIT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]), .out_stages(st[2]));

  bubble_sort_seq #(.DIM(10), .WIDTH(8), .PPC(2), .DESCEND(0), .SIGNED(0), .EARLY_EXIT(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_d), .in_ready(ir_d), .in_data(id_d),
    .out_valid(ov_d), .out_ready(ordy_d), .out_data(od_d), .busy(bz_d), .out_stages(st_d));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid4(input int idx, output int n);
    n = 0;
    while (ov[idx] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic sort4(input int idx, input string tag, input logic [31:0] din,
                       input logic [31:0] exp, input int exp_stg, input int exp_edges);
    int n;
    @(negedge clk);
    iv[idx] = 1'b1;
    id[idx] = din;
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    check({tag, "_busy"}, 128'(bz[idx]), 128'(1));
    wait_valid4(idx, n);
    check({tag, "_edges"}, 128'(n), 128'(exp_edges));
    check({tag, "_data"}, 128'(od[idx]), 128'(exp));
    check({tag, "_stages"}, 128'(st[idx]), 128'(exp_stg));
    check({tag, "_in_ready"}, 128'(ir[idx]), 128'(0));
  endtask

  task automatic rel4(input int idx, input string tag);
    @(negedge clk);
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    check({tag, "_rel_in_ready"}, 128'(ir[idx]), 128'(1));
    check({tag, "_rel_out_valid"}, 128'(ov[idx]), 128'(0));
  endtask

  initial begin
    int n;
    logic [79:0] rev, asc;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0;
    end
    iv_d = 1'b0; id_d = '0; ordy_d = 1'b0;
    #12;
    check("rst_in_ready", 128'(ir[0]), 128'(1));
    check("rst_out_valid", 128'(ov[0]), 128'(0));
    check("rst_busy", 128'(bz[0]), 128'(0));
    check("rst_out_data", 128'(od[0]), 128'(0));
    check("rst_out_stages", 128'(st[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // {3,1,4,2} -> {1,2,3,4}: swaps in stages 0,1; exit after stage 3
    sort4(0, "asc", {8'd2, 8'd4, 8'd1, 8'd3}, {8'd4, 8'd3, 8'd2, 8'd1}, 4, 4);
    rel4(0, "asc");
    sort4(0, "sorted_ee", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 2, 2);
    rel4(0, "sorted_ee");
    sort4(1, "sorted_noee", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 4, 4);
    rel4(1, "sorted_noee");
    // signed descending {-1,2,-128,0} -> {2,0,-1,-128}
    sort4(2, "sdesc", {8'h00, 8'h80, 8'h02, 8'hFF}, {8'h80, 8'hFF, 8'h00, 8'h02}, 4, 4);
    rel4(2, "sdesc");

    // DIM=10, PPC=2 reverse input
    for (int k = 0; k < 10; k++) begin
      rev[k*8 +: 8] = 8'(9 - k);
      asc[k*8 +: 8] = 8'(k);
    end
    @(negedge clk);
    iv_d = 1'b1;
    id_d = rev;
    @(posedge clk); #1;
    iv_d = 1'b0;
    n = 0;
    while (ov_d !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ppc2_edges", 128'(n), 128'(5));
    check("ppc2_data", 128'(od_d), 128'(asc));
    check("ppc2_stages", 128'(st_d), 128'(10));
    @(negedge clk);
    ordy_d = 1'b1;
    @(posedge clk); #1;
    ordy_d = 1'b0;
    check("ppc2_rel_in_ready", 128'(ir_d), 128'(1));

    // Backpressure with a second array waiting on in_valid
    sort4(0, "bp", {8'd2, 8'd4, 8'd1, 8'd3}, {8'd4, 8'd3, 8'd2, 8'd1}, 4, 4);
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = {8'd4, 8'd3, 8'd1, 8'd2};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_data", 128'(od[0]), 128'({8'd4, 8'd3, 8'd2, 8'd1}));
      check("bp_hold_in_ready", 128'(ir[0]), 128'(0));
      check("bp_hold_out_valid", 128'(ov[0]), 128'(1));
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("bp_idle_in_ready", 128'(ir[0]), 128'(1));
    check("bp_idle_out_valid", 128'(ov[0]), 128'(0));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp2_busy", 128'(bz[0]), 128'(1));
    wait_valid4(0, n);
    // {2,1,3,4}: swap in stage 0 only, zero swaps in stages 1 and 2
    check("bp2_edges", 128'(n), 128'(3));
    check("bp2_data", 128'(od[0]), 128'({8'd4, 8'd3, 8'd2, 8'd1}));
    check("bp2_stages", 128'(st[0]), 128'(3));
    rel4(0, "bp2");

    // Reset asserted mid-sort
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = {8'd2, 8'd4, 8'd1, 8'd3};
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 128'(bz[0]), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(ov[0]), 128'(0));
    check("arst_busy", 128'(bz[0]), 128'(0));
    check("arst_in_ready", 128'(ir[0]), 128'(1));
    check("arst_out_data", 128'(od[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // {5,5,1,5} -> {1,5,5,5}
    sort4(0, "post_rst", {8'd5, 8'd1, 8'd5, 8'd5}, {8'd5, 8'd5, 8'd5, 8'd1}, 4, 4);
    rel4(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
